// File: rtl/ps2_bird_keys.sv
// ps2_bird_keys: PS/2 receiver and scan-code decoder producing up/down levels and a start pulse.
// Optional macro PS2_WASD_EN adds W/S keys as alternates for up/down.
module ps2_bird_keys #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       start,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, nxt;
    logic [2:0] ck_s;
    logic [1:0] dt_s;
    logic [7:0] shreg;
    logic [2:0] cnt;
    logic par;
    logic [TW-1:0] tmo;
    logic fall, din, timeout, frame_ok, frame_bad;
    logic ext, brk, arrow_up, arrow_down;
    assign fall = ck_s[2] & ~ck_s[1];
    assign din = dt_s[1];
    // synchronize the PS/2 pins; idle-high reset values avoid a false edge after reset
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ck_s <= 3'b111;
            dt_s <= 2'b11;
        end else begin
            ck_s <= {ck_s[1:0], ps2_clk};
            dt_s <= {dt_s[0], ps2_data};
        end
    end
    // frame state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else state <= nxt;
    end
    // next state and frame verdicts; a timeout only fires on a cycle without an edge
    always_comb begin
        nxt = state;
        timeout = state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1);
        frame_ok = fall && state == STOP && (^{shreg, par}) && din;
        frame_bad = fall && state == STOP && !frame_ok;
        if (fall) begin
            case (state)
                IDLE:    nxt = din ? IDLE : DATA;
                DATA:    nxt = cnt == 3'd7 ? PARITY : DATA;
                PARITY:  nxt = STOP;
                default: nxt = IDLE;
            endcase
        end
        if (timeout) nxt = IDLE;
    end
    // bit shifter, parity capture and inactivity counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shreg <= 8'h00;
            cnt <= 3'd0;
            par <= 1'b0;
            tmo <= '0;
        end else begin
            tmo <= (fall || state == IDLE) ? '0 : tmo + TW'(1);
            if (fall && state == IDLE) cnt <= 3'd0;
            if (fall && state == DATA) begin
                shreg <= {din, shreg[7:1]};
                cnt <= cnt + 3'd1;
            end
            if (fall && state == PARITY) par <= din;
        end
    end
    // received-byte outputs and error pulse
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rx_byte <= 8'h00;
            rx_valid <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            rx_valid <= frame_ok;
            rx_err <= frame_bad | timeout;
            if (frame_ok) rx_byte <= shreg;
        end
    end
`ifdef PS2_WASD_EN
    logic w_held, s_held;
    assign up = arrow_up | w_held;
    assign down = arrow_down | s_held;
`else
    assign up = arrow_up;
    assign down = arrow_down;
`endif
    // scan-code decoder: prefixes set flags, any other code consumes them
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ext <= 1'b0;
            brk <= 1'b0;
            arrow_up <= 1'b0;
            arrow_down <= 1'b0;
            start <= 1'b0;
`ifdef PS2_WASD_EN
            w_held <= 1'b0;
            s_held <= 1'b0;
`endif
        end else begin
            start <= frame_ok && !ext && !brk && shreg == 8'h29;
            if (frame_ok) begin
                if (shreg == 8'hE0) ext <= 1'b1;
                else if (shreg == 8'hF0) brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (ext && shreg == 8'h75) arrow_up <= ~brk;
                    if (ext && shreg == 8'h72) arrow_down <= ~brk;
`ifdef PS2_WASD_EN
                    if (!ext && shreg == 8'h1D) w_held <= ~brk;
                    if (!ext && shreg == 8'h1B) s_held <= ~brk;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_bird_keys.sv
// tb_ps2_bird_keys: directed and randomized PS/2 frames checked against a key-state reference model.
module tb_ps2_bird_keys;
    localparam int TMO = 200;
    localparam int HALF = 20;
    logic clk = 0, clr = 0, ps2_clk = 1, ps2_data = 1;
    logic up, down, start, rx_valid, rx_err;
    logic [7:0] rx_byte;
    int n_tests = 0, n_fail = 0;
    int nv = 0, ne = 0, ns = 0;
    logic [7:0] last_byte = 8'h00;
    bit m_ext, m_brk, m_aup, m_adn, m_w, m_s;
    int m_start;

    ps2_bird_keys #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .up(up), .down(down), .start(start),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err)
    );

    always #10 clk = ~clk;

    // pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            nv++;
            last_byte = rx_byte;
        end
        if (rx_err) ne++;
        if (start) ns++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // key-state model: held set keyed by {extended, code}
    function automatic void model(input logic [7:0] b);
        m_start = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            case ({m_ext, b})
                9'h175:  m_aup = !m_brk;
                9'h172:  m_adn = !m_brk;
                9'h01D:  m_w = !m_brk;
                9'h01B:  m_s = !m_brk;
                9'h029:  m_start = m_brk ? 0 : 1;
                default: ;
            endcase
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic bit exp_up();
`ifdef PS2_WASD_EN
        return m_aup | m_w;
`else
        return m_aup;
`endif
    endfunction

    function automatic bit exp_dn();
`ifdef PS2_WASD_EN
        return m_adn | m_s;
`else
        return m_adn;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        wait_cyc(HALF);
        ps2_clk = 0;
        wait_cyc(HALF);
        ps2_clk = 1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par = 0, input logic stp = 1);
        int v0, e0, s0;
        bit good;
        v0 = nv;
        e0 = ne;
        s0 = ns;
        good = !bad_par && stp;
        if (good) model(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_data = stp;
        wait_cyc(HALF);
        ps2_clk = 0;
        wait_cyc(3);
        check("up_latency", up, exp_up());
        check("down_latency", down, exp_dn());
        wait_cyc(HALF - 3);
        ps2_clk = 1;
        ps2_data = 1;
        wait_cyc(HALF);
        check("valid_count", nv - v0, good);
        check("err_count", ne - e0, !good);
        check("start_count", ns - s0, good ? m_start : 0);
        if (good) check("rx_byte", last_byte, b);
    endtask

    initial begin
        logic [7:0] codes [7] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h29, 8'h1D, 8'h1B};
        int e0, v0;
        wait_cyc(5);
        check("rst_out", {up, down, start, rx_valid, rx_err}, 0);
        check("rst_byte", rx_byte, 8'h00);
        clr = 1;
        wait_cyc(5);
        frame(8'hE0); frame(8'h75);
        check("tp_up_set", {up, down}, 2'b10);
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        check("tp_up_clr", up, 0);
        frame(8'hE0); frame(8'h75); frame(8'hE0); frame(8'h72);
        check("tp_both", {up, down}, 2'b11);
        frame(8'h29);
        frame(8'hF0); frame(8'h29);
        frame(8'h75, 1, 1);
        check("tp_par_up", up, 1);
        frame(8'h75, 0, 0);
        e0 = ne;
        v0 = nv;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wait_cyc(TMO + 50);
        check("timeout_err", ne - e0, 1);
        check("timeout_valid", nv - v0, 0);
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        frame(8'hE0); frame(8'h75);
        check("tp_after_tmo", up, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        clr = 0;
        #1;
        check("async_up", up, 0);
        check("async_byte", rx_byte, 8'h00);
        {m_ext, m_brk, m_aup, m_adn, m_w, m_s} = '0;
        ps2_data = 1;
        ps2_clk = 1;
        wait_cyc(3);
        clr = 1;
        wait_cyc(5);
        frame(8'hE0); frame(8'h75);
        check("post_rst_up", up, 1);
        frame(8'h1D);
        frame(8'hF0); frame(8'h1D);
        for (int n = 0; n < 55; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = r < 7 ? codes[r] : 8'($urandom);
            r = $urandom_range(0, 9);
            frame(b, r == 0, r != 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
